// File: rtl/mioc_pkg.sv
// Shared types and constants for the MIOC DRAM strobe sequencer.
// The state enum and refresh-queue depth live here so the top and bench agree.
package mioc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    CAS,
    PRE,
    REF
  } state_t;

  localparam logic [1:0] REFQ_MAX = 2'd3;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mioc_phase_cnt.sv
// Loadable down-counter that times every sequencer phase.
// The terminal count is asserted while the count sits at zero (the last cycle of a phase).
module mioc_phase_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_loadVal,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_loadVal;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM strobe sequencer: RAS/MUX/per-bank CAS generation with refresh queueing,
// a one-deep pending access slot and CPU wait-state requests.
module mioc_dram_seq
  import mioc_pkg::*;
#(
  parameter int N_BANKS       = 2,
  parameter int BANK_W        = 3,
  parameter int RAS_MUX_CYC   = 1,
  parameter int MUX_CAS_CYC   = 1,
  parameter int CAS_HOLD_CYC  = 2,
  parameter int PRECHARGE_CYC = 1
) (
  input  logic               B_PHI,
  input  logic               RST,
  input  logic               BMREQ_N,
  input  logic               BRD_N,
  input  logic               N_BWR,
  input  logic               BRFSH_N,
  input  logic               DMA_N,
  input  logic [BANK_W-1:0]  BANK,
  input  logic               ROW_A7,
  input  logic               COL_A7,
  output logic               RAS_N,
  output logic [N_BANKS-1:0] CAS_N,
  output logic               MUX,
  output logic               RA7,
  output logic               WAIT_N,
  output logic               REF_OVF
);

  localparam int REF_CYC = RAS_MUX_CYC + MUX_CAS_CYC + CAS_HOLD_CYC;
  localparam int MAX_CYC = maxOf(maxOf(REF_CYC, PRECHARGE_CYC), 1);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_ROW = CNT_W'(RAS_MUX_CYC - 1);
  localparam logic [CNT_W-1:0] LD_COL = CNT_W'(MUX_CAS_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CAS = CNT_W'(CAS_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_REF = CNT_W'(REF_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(PRECHARGE_CYC - 1);
  localparam logic [BANK_W:0]  NB_LIMIT = (BANK_W + 1)'(N_BANKS);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_bmreqCur;
  logic                r_bmreqPrev;
  logic                r_rdN;
  logic                r_wrN;
  logic                r_rfshN;
  logic                r_dmaN;
  logic [BANK_W-1:0]   r_bank;
  logic [BANK_W-1:0]   r_curBank;
  logic [BANK_W-1:0]   w_nextBank;
  logic                r_pendValid;
  logic [BANK_W-1:0]   r_pendBank;
  logic [1:0]          r_refCnt;
  logic                r_refOvf;
  logic                r_rasN;
  logic [N_BANKS-1:0]  r_casN;
  logic                r_mux;

  logic                w_fall;
  logic [BANK_W-1:0]   w_effBank;
  logic                w_bankOk;
  logic                w_accReq;
  logic                w_refReq;
  logic                w_busy;
  logic                w_accBusy;
  logic                w_refBusy;
  logic                w_launchPend;
  logic                w_refDec;
  logic                w_tc;
  logic                w_load;
  logic [CNT_W-1:0]    w_loadVal;
  logic [N_BANKS-1:0]  w_casOneHot;

  // Bus qualifiers are sampled together with BMREQ_N so one edge decides a request.
  always_ff @(posedge B_PHI) begin
    if (RST) begin
      r_bmreqCur  <= 1'b1;
      r_bmreqPrev <= 1'b1;
      r_rdN       <= 1'b1;
      r_wrN       <= 1'b1;
      r_rfshN     <= 1'b1;
      r_dmaN      <= 1'b1;
      r_bank      <= '0;
    end else begin
      r_bmreqCur  <= BMREQ_N;
      r_bmreqPrev <= r_bmreqCur;
      r_rdN       <= BRD_N;
      r_wrN       <= N_BWR;
      r_rfshN     <= BRFSH_N;
      r_dmaN      <= DMA_N;
      r_bank      <= BANK;
    end
  end

  assign w_fall    = r_bmreqPrev & ~r_bmreqCur;
  assign w_effBank = r_dmaN ? r_bank : '0;
  assign w_bankOk  = ({1'b0, w_effBank} < NB_LIMIT);
  assign w_accReq  = w_fall & r_rfshN & (~r_rdN | ~r_wrN) & w_bankOk;
  assign w_refReq  = w_fall & ~r_rfshN;
  // Queued work counts as busy so a fresh request never overtakes it.
  assign w_busy    = (r_state != IDLE) | r_pendValid | (r_refCnt != 2'd0);
  assign w_accBusy = w_accReq & w_busy;
  assign w_refBusy = w_refReq & w_busy;

  always_comb begin
    w_nextState  = r_state;
    w_nextBank   = r_curBank;
    w_launchPend = 1'b0;
    w_refDec     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pendValid) begin
          w_nextState  = ROW;
          w_nextBank   = r_pendBank;
          w_launchPend = 1'b1;
        end else if (r_refCnt != 2'd0) begin
          w_nextState = REF;
          w_refDec    = 1'b1;
        end else if (w_accReq) begin
          w_nextState = ROW;
          w_nextBank  = w_effBank;
        end else if (w_refReq) begin
          w_nextState = REF;
        end
      end
      ROW: if (w_tc) w_nextState = COL;
      COL: if (w_tc) w_nextState = CAS;
      CAS: if (w_tc) w_nextState = PRE;
      REF: if (w_tc) w_nextState = PRE;
      PRE: begin
        if (w_tc) begin
          if (r_pendValid) begin
            w_nextState  = ROW;
            w_nextBank   = r_pendBank;
            w_launchPend = 1'b1;
          end else if (r_refCnt != 2'd0) begin
            w_nextState = REF;
            w_refDec    = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_loadVal = '0;
    case (w_nextState)
      ROW:     w_loadVal = LD_ROW;
      COL:     w_loadVal = LD_COL;
      CAS:     w_loadVal = LD_CAS;
      REF:     w_loadVal = LD_REF;
      PRE:     w_loadVal = LD_PRE;
      default: w_loadVal = '0;
    endcase
  end

  assign w_load = (w_nextState != r_state);

  mioc_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phaseCnt (
    .i_clk    (B_PHI),
    .i_rst    (RST),
    .i_load   (w_load),
    .i_loadVal(w_loadVal),
    .o_tc     (w_tc)
  );

  assign w_casOneHot = N_BANKS'(1) << r_curBank;

  // Strobes are registered from the next state so they switch with the state edge.
  always_ff @(posedge B_PHI) begin
    if (RST) begin
      r_state   <= IDLE;
      r_curBank <= '0;
      r_rasN    <= 1'b1;
      r_casN    <= '1;
      r_mux     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_curBank <= w_nextBank;
      r_rasN    <= !(w_nextState inside {ROW, COL, CAS, REF});
      r_mux     <= (w_nextState == COL) || (w_nextState == CAS);
      r_casN    <= (w_nextState == CAS) ? ~w_casOneHot : '1;
    end
  end

  always_ff @(posedge B_PHI) begin
    if (RST) begin
      r_pendValid <= 1'b0;
      r_pendBank  <= '0;
    end else if (w_launchPend) begin
      r_pendValid <= 1'b0;
    end else if (w_accBusy && !r_pendValid) begin
      r_pendValid <= 1'b1;
      r_pendBank  <= w_effBank;
    end
  end

  // An increment and a decrement on the same edge cancel out.
  always_ff @(posedge B_PHI) begin
    if (RST) begin
      r_refCnt <= 2'd0;
      r_refOvf <= 1'b0;
    end else if (w_refBusy && !w_refDec) begin
      if (r_refCnt == REFQ_MAX) begin
        r_refOvf <= 1'b1;
      end else begin
        r_refCnt <= r_refCnt + 2'd1;
      end
    end else if (w_refDec && !w_refBusy) begin
      r_refCnt <= r_refCnt - 2'd1;
    end
  end

  assign RAS_N   = r_rasN;
  assign CAS_N   = r_casN;
  assign MUX     = r_mux;
  assign RA7     = r_mux ? COL_A7 : ROW_A7;
  assign WAIT_N  = ~r_pendValid;
  assign REF_OVF = r_refOvf;

endmodule

// File: tb/tb_mioc_dram_seq.sv
// Scoreboard bench for mioc_dram_seq: per-cycle expected strobe vectors are queued
// from the documented timing and popped as the DUT runs.
module tb_mioc_dram_seq;

  logic       B_PHI = 1'b0;
  logic       RST;
  logic       BMREQ_N;
  logic       BRD_N;
  logic       N_BWR;
  logic       BRFSH_N;
  logic       DMA_N;
  logic [2:0] BANK;
  logic       ROW_A7;
  logic       COL_A7;

  logic       d1RasN, d1Mux, d1Ra7, d1WaitN, d1RefOvf;
  logic [1:0] d1CasN;
  logic       d2RasN, d2Mux, d2Ra7, d2WaitN, d2RefOvf;
  logic [1:0] d2CasN;

  int errors = 0;
  int checks = 0;
  logic [5:0] expQ[$];

  always #5 B_PHI = ~B_PHI;

  // Default timing instance.
  mioc_dram_seq dut1 (
    .B_PHI(B_PHI), .RST(RST), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR),
    .BRFSH_N(BRFSH_N), .DMA_N(DMA_N), .BANK(BANK), .ROW_A7(ROW_A7), .COL_A7(COL_A7),
    .RAS_N(d1RasN), .CAS_N(d1CasN), .MUX(d1Mux), .RA7(d1Ra7), .WAIT_N(d1WaitN),
    .REF_OVF(d1RefOvf)
  );

  // Long CAS hold instance for refresh saturation and reset-in-CAS.
  mioc_dram_seq #(.CAS_HOLD_CYC(8)) dut2 (
    .B_PHI(B_PHI), .RST(RST), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR),
    .BRFSH_N(BRFSH_N), .DMA_N(DMA_N), .BANK(BANK), .ROW_A7(ROW_A7), .COL_A7(COL_A7),
    .RAS_N(d2RasN), .CAS_N(d2CasN), .MUX(d2Mux), .RA7(d2Ra7), .WAIT_N(d2WaitN),
    .REF_OVF(d2RefOvf)
  );

  task automatic busIdle();
    BMREQ_N = 1'b1;
    BRD_N   = 1'b1;
    N_BWR   = 1'b1;
    BRFSH_N = 1'b1;
    DMA_N   = 1'b1;
    BANK    = 3'd0;
  endtask

  task automatic doReset();
    busIdle();
    RST = 1'b1;
    repeat (2) @(posedge B_PHI);
    #1;
    RST = 1'b0;
    @(posedge B_PHI);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] expV, gotV;
    logic [6:0] got2;
    busIdle();
    ROW_A7 = 1'b1;
    COL_A7 = 1'b0;
    RST = 1'b1;
    for (int c = 0; c <= 3; c++) expQ.push_back(6'b1_11_0_1_1);
    for (int c = 0; c <= 3; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL reset_dut1 c=%0d got=%b expected=%b", c, gotV, expV);
      end
      got2 = {d2RasN, d2CasN, d2Mux, d2WaitN, d2RefOvf, d2Ra7};
      checks++;
      if (got2 !== 7'b1_11_0_1_0_1 || d1RefOvf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_dut2 c=%0d got=%b ovf1=%b expected=1110101 ovf1=0", c, got2, d1RefOvf);
      end
      if (c == 1) RST = 1'b0;
    end
    ROW_A7 = 1'b0;
    COL_A7 = 1'b1;
  endtask

  task automatic test_read_bank1();
    logic [5:0] expV, gotV;
    logic r, m;
    logic [1:0] cs;
    doReset();
    for (int c = 0; c <= 6; c++) begin
      r  = !(c >= 1 && c <= 4);
      m  = (c >= 2 && c <= 4);
      cs = (c >= 3 && c <= 4) ? 2'b01 : 2'b11;
      expQ.push_back({r, cs, m, 1'b1, m});
    end
    BMREQ_N = 1'b0;
    BRD_N   = 1'b0;
    BANK    = 3'd1;
    for (int c = 0; c <= 6; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL read_bank1 c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 0) BANK = 3'd0;
      if (c == 2) busIdle();
    end
  endtask

  task automatic test_refresh();
    logic [5:0] expV, gotV;
    doReset();
    for (int c = 0; c <= 6; c++)
      expQ.push_back({!(c >= 1 && c <= 4), 2'b11, 1'b0, 1'b1, 1'b0});
    BMREQ_N = 1'b0;
    BRFSH_N = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL refresh c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 1) busIdle();
    end
  endtask

  task automatic test_access_during_refresh();
    logic [5:0] expV, gotV;
    logic r, m, w;
    logic [1:0] cs;
    doReset();
    for (int c = 0; c <= 11; c++) begin
      r  = !((c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      m  = (c >= 7 && c <= 9);
      cs = (c >= 8 && c <= 9) ? 2'b10 : 2'b11;
      w  = !(c >= 3 && c <= 5);
      expQ.push_back({r, cs, m, w, m});
    end
    BMREQ_N = 1'b0;
    BRFSH_N = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL access_during_refresh c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 0) begin
        BMREQ_N = 1'b1;
        BRFSH_N = 1'b1;
      end
      if (c == 1) begin
        BMREQ_N = 1'b0;
        BRD_N   = 1'b0;
        BANK    = 3'd0;
      end
      if (c == 3) busIdle();
    end
  endtask

  task automatic test_dma_and_bad_bank();
    logic [5:0] expV, gotV;
    logic r, m;
    logic [1:0] cs;
    doReset();
    for (int c = 0; c <= 8; c++) begin
      r  = !(c >= 1 && c <= 4);
      m  = (c >= 2 && c <= 4);
      cs = (c >= 3 && c <= 4) ? 2'b10 : 2'b11;
      expQ.push_back({r, cs, m, 1'b1, m});
    end
    BMREQ_N = 1'b0;
    N_BWR   = 1'b0;
    DMA_N   = 1'b0;
    BANK    = 3'd1;
    for (int c = 0; c <= 8; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL dma_bank0 c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 2) busIdle();
    end
    for (int c = 0; c <= 6; c++) expQ.push_back(6'b1_11_0_1_0);
    BMREQ_N = 1'b0;
    BRD_N   = 1'b0;
    BANK    = 3'd3;
    for (int c = 0; c <= 6; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d1RasN, d1CasN, d1Mux, d1WaitN, d1Ra7};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL bank_out_of_range c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 2) busIdle();
    end
  endtask

  task automatic test_refresh_saturate();
    logic [5:0] expV, gotV;
    logic r, m, o;
    logic [1:0] cs;
    doReset();
    for (int c = 0; c <= 46; c++) begin
      r  = !((c >= 1 && c <= 10) || (c >= 12 && c <= 21) ||
             (c >= 23 && c <= 32) || (c >= 34 && c <= 43));
      m  = (c >= 2 && c <= 10);
      cs = (c >= 3 && c <= 10) ? 2'b10 : 2'b11;
      o  = (c >= 9);
      expQ.push_back({r, cs, m, 1'b1, o});
    end
    BMREQ_N = 1'b0;
    BRD_N   = 1'b0;
    BANK    = 3'd0;
    for (int c = 0; c <= 46; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d2RasN, d2CasN, d2Mux, d2WaitN, d2RefOvf};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL refresh_saturate c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 0) begin
        BMREQ_N = 1'b1;
        BRD_N   = 1'b1;
      end
      if (c == 1) begin
        BMREQ_N = 1'b0;
        BRFSH_N = 1'b0;
      end
      if (c == 2 || c == 4 || c == 6) BMREQ_N = 1'b1;
      if (c == 3 || c == 5 || c == 7) BMREQ_N = 1'b0;
      if (c == 8) busIdle();
    end
  endtask

  task automatic test_reset_in_cas();
    logic [5:0] expV, gotV;
    logic r, m, w;
    logic [1:0] cs;
    doReset();
    for (int c = 0; c <= 20; c++) begin
      r  = !(c >= 1 && c <= 6);
      m  = (c >= 2 && c <= 6);
      cs = (c >= 3 && c <= 6) ? 2'b01 : 2'b11;
      w  = !(c >= 5 && c <= 6);
      expQ.push_back({r, cs, m, w, 1'b0});
    end
    BMREQ_N = 1'b0;
    BRD_N   = 1'b0;
    BANK    = 3'd1;
    for (int c = 0; c <= 20; c++) begin
      @(posedge B_PHI);
      #1;
      gotV = {d2RasN, d2CasN, d2Mux, d2WaitN, d2RefOvf};
      expV = expQ.pop_front();
      checks++;
      if (gotV !== expV) begin
        errors++;
        $display("[TB] FAIL reset_in_cas c=%0d got=%b expected=%b", c, gotV, expV);
      end
      if (c == 0) BMREQ_N = 1'b1;
      if (c == 1) begin
        BMREQ_N = 1'b0;
        BRD_N   = 1'b1;
        BRFSH_N = 1'b0;
      end
      if (c == 2) begin
        BMREQ_N = 1'b1;
        BRFSH_N = 1'b1;
      end
      if (c == 3) begin
        BMREQ_N = 1'b0;
        BRD_N   = 1'b0;
        BANK    = 3'd0;
      end
      if (c == 6) begin
        RST = 1'b1;
        busIdle();
      end
      if (c == 7) RST = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIdle();
    RST    = 1'b1;
    ROW_A7 = 1'b0;
    COL_A7 = 1'b1;
    test_reset();
    test_read_bank1();
    test_refresh();
    test_access_during_refresh();
    test_dma_and_bad_bank();
    test_refresh_saturate();
    test_reset_in_cas();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
